// File: rtl/mem_datos_bus_if.sv
// Request/response bus for mem_datos_bus: one outstanding request,
// single-cycle response strobe and a busy flag while memory is being cleared.
interface mem_datos_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_datos_bus.sv
// Byte-addressable data memory with a fixed-latency response, lane-masked
// stores, sign/zero-extended loads and a self-clear after every reset.
module mem_datos_bus #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int          DEPTH     = 1024,
  parameter int          LAT       = 1
) (
  input  logic           CLK,
  input  logic           RST,
  mem_datos_bus_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0]   offset;
  logic          in_range, misaligned, req_err, accept, clear_we;
  logic [AW-1:0] widx;
  logic [31:0]   rd_word, shifted, load_val;

  // Range test is done without wrap: the address must not lie below the base.
  always_comb begin
    offset     = bus.req_addr - BASE_ADDR;
    in_range   = (bus.req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_err    = (bus.req_size == 2'b11) || misaligned || !in_range;
    widx       = offset[AW+1:2];
    accept     = (state_q == IDLE) && bus.req_valid && !RST;
    clear_we   = (state_q == CLEAR) && !RST;
  end

  // One RAM per byte lane gives lane-masked stores without read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_lane_q;
    logic          lane_sel, lane_we;
    logic [7:0]    lane_wdata;
    logic [AW-1:0] lane_addr;

    always_comb begin
      lane_sel   = 1'b1;
      lane_wdata = bus.req_wdata[8*gi +: 8];
      case (bus.req_size)
        2'b00: begin
          lane_sel   = (bus.req_addr[1:0] == LANE);
          lane_wdata = bus.req_wdata[7:0];
        end
        2'b01: begin
          lane_sel   = (bus.req_addr[1] == LANE[1]);
          lane_wdata = bus.req_wdata[8*(gi % 2) +: 8];
        end
        default: ;
      endcase
      lane_we   = clear_we || (accept && bus.req_we && !req_err && lane_sel);
      lane_addr = widx;
      if (clear_we) begin
        lane_addr  = idx_q;
        lane_wdata = 8'h00;
      end
    end

    always_ff @(posedge CLK) begin
      if (lane_we)
        mem[lane_addr] <= lane_wdata;
      if (accept && !bus.req_we)
        rd_lane_q <= mem[widx];
    end

    assign rd_word[8*gi +: 8] = rd_lane_q;
  end

  always_comb begin
    shifted  = rd_word >> {lane_q, 3'b000};
    load_val = rd_word;
    case (size_q)
      2'b00: load_val = uns_q ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_val = uns_q ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    case (state_q)
      CLEAR: begin
        if (idx_q == AW'(DEPTH - 1))
          state_d = IDLE;
        else
          idx_d = idx_q + 1'b1;
      end
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 2'(LAT - 1);
          lane_d  = bus.req_addr[1:0];
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          we_d    = bus.req_we;
          err_d   = req_err;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (err_q || we_q) ? 32'h0 : load_val;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CLEAR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      cnt_q       <= 2'd0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_datos_bus.sv
// Bench for mem_datos_bus: a LAT=1 and a LAT=4 instance (DEPTH=16), vector
// table through a scoreboard plus hand sequences for clear and mid-flight reset.
module tb_mem_datos_bus;
  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst4 = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_datos_bus_if m1 ();
  mem_datos_bus_if m4 ();

  mem_datos_bus #(.BASE_ADDR(32'hFFFF0000), .DEPTH(16), .LAT(1)) dut1 (
    .CLK(clk), .RST(rst1), .bus(m1));
  mem_datos_bus #(.BASE_ADDR(32'hFFFF0000), .DEPTH(16), .LAT(4)) dut4 (
    .CLK(clk), .RST(rst4), .bus(m4));

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  vec_t vecs[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mkv(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp = exp; v.exp_err = exp_err;
    return v;
  endfunction

  // Scoreboard side: each response is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m1.rsp_valid) begin
      if (q1.size() == 0) check("dut1 unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        $display("dut1 rsp rdata=%h err=%0d (want %h/%0d)", m1.rsp_rdata, m1.rsp_err, e.rdata, e.err);
        check("dut1 rsp_rdata", m1.rsp_rdata, e.rdata);
        check("dut1 rsp_err", 32'(m1.rsp_err), 32'(e.err));
        check("dut1 latency", 32'(cyc - e.acc), 32'd1);
      end
    end else begin
      check("dut1 idle rsp_rdata", m1.rsp_rdata, 32'h0);
      check("dut1 idle rsp_err", 32'(m1.rsp_err), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m4.rsp_valid) begin
      if (q4.size() == 0) check("dut4 unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        $display("dut4 rsp rdata=%h err=%0d (want %h/%0d)", m4.rsp_rdata, m4.rsp_err, e.rdata, e.err);
        check("dut4 rsp_rdata", m4.rsp_rdata, e.rdata);
        check("dut4 rsp_err", 32'(m4.rsp_err), 32'(e.err));
        check("dut4 latency", 32'(cyc - e.acc), 32'd4);
      end
    end
  end

  task automatic do_req(input int sel, input vec_t v);
    int   n;
    logic rdy;
    exp_t e;
    @(negedge clk);
    if (sel == 1) begin
      m1.req_we = v.we; m1.req_size = v.size; m1.req_unsigned = v.uns;
      m1.req_addr = v.addr; m1.req_wdata = v.wdata; m1.req_valid = 1'b1;
    end else begin
      m4.req_we = v.we; m4.req_size = v.size; m4.req_unsigned = v.uns;
      m4.req_addr = v.addr; m4.req_wdata = v.wdata; m4.req_valid = 1'b1;
    end
    n = 0;
    rdy = (sel == 1) ? m1.req_ready : m4.req_ready;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = (sel == 1) ? m1.req_ready : m4.req_ready;
    end
    check("req_ready before accept", 32'(rdy), 32'd1);
    e.rdata = v.exp; e.err = v.exp_err; e.acc = cyc + 1;
    if (rdy) begin
      if (sel == 1) q1.push_back(e);
      else q4.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel == 1) m1.req_valid = 1'b0;
    else m4.req_valid = 1'b0;
    n = 0;
    while (((sel == 1) ? q1.size() : q4.size()) != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("response arrived", 32'((sel == 1) ? q1.size() : q4.size()), 32'd0);
    q1.delete();
    q4.delete();
  endtask

  task automatic wait_clear(input string name, input int sel);
    int r;
    int n;
    r = cyc;
    n = 0;
    while (((sel == 1) ? m1.busy : m4.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cyc - r), 32'd16);
    check("req_ready after clear", 32'((sel == 1) ? m1.req_ready : m4.req_ready), 32'd1);
  endtask

  initial begin
    int n;
    int nrsp;
    m1.req_valid = 1'b0; m1.req_we = 1'b0; m1.req_size = 2'b00; m1.req_unsigned = 1'b0;
    m1.req_addr = 32'h0; m1.req_wdata = 32'h0;
    m4.req_valid = 1'b0; m4.req_we = 1'b0; m4.req_size = 2'b00; m4.req_unsigned = 1'b0;
    m4.req_addr = 32'h0; m4.req_wdata = 32'h0;

    //                we    size   uns   addr           wdata          expected       err
    vecs[0]  = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0000, 32'h0,        32'h00000000, 1'b0);
    vecs[1]  = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF003C, 32'h0,        32'h00000000, 1'b0);
    vecs[2]  = mkv(1'b1, 2'b10, 1'b0, 32'hFFFF0008, 32'hDEADBEEF, 32'h00000000, 1'b0);
    vecs[3]  = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0008, 32'h0,        32'hDEADBEEF, 1'b0);
    vecs[4]  = mkv(1'b1, 2'b00, 1'b0, 32'hFFFF000A, 32'hFFFFFF7F, 32'h00000000, 1'b0);
    vecs[5]  = mkv(1'b0, 2'b00, 1'b0, 32'hFFFF000B, 32'h0,        32'hFFFFFFDE, 1'b0);
    vecs[6]  = mkv(1'b0, 2'b01, 1'b1, 32'hFFFF000A, 32'h0,        32'h0000DE7F, 1'b0);
    vecs[7]  = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0008, 32'h0,        32'hDE7FBEEF, 1'b0);
    vecs[8]  = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0002, 32'h0,        32'h00000000, 1'b1);
    vecs[9]  = mkv(1'b0, 2'b01, 1'b0, 32'hFFFF0001, 32'h0,        32'h00000000, 1'b1);
    vecs[10] = mkv(1'b0, 2'b10, 1'b0, 32'hFFFEFFFC, 32'h0,        32'h00000000, 1'b1);
    vecs[11] = mkv(1'b0, 2'b00, 1'b0, 32'hFFFF0040, 32'h0,        32'h00000000, 1'b1);
    vecs[12] = mkv(1'b1, 2'b10, 1'b0, 32'hFFFF0040, 32'h12345678, 32'h00000000, 1'b1);
    vecs[13] = mkv(1'b1, 2'b11, 1'b0, 32'hFFFF0008, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    vecs[14] = mkv(1'b1, 2'b01, 1'b0, 32'hFFFF0009, 32'h0000AAAA, 32'h00000000, 1'b1);
    vecs[15] = mkv(1'b1, 2'b00, 1'b0, 32'hFFFEFFFF, 32'h00000055, 32'h00000000, 1'b1);
    vecs[16] = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0000, 32'h0,        32'h00000000, 1'b0);
    vecs[17] = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0008, 32'h0,        32'hDE7FBEEF, 1'b0);
    vecs[18] = mkv(1'b0, 2'b01, 1'b0, 32'hFFFF0008, 32'h0,        32'hFFFFBEEF, 1'b0);
    vecs[19] = mkv(1'b0, 2'b00, 1'b1, 32'hFFFF0009, 32'h0,        32'h000000BE, 1'b0);
    vecs[20] = mkv(1'b0, 2'b00, 1'b0, 32'hFFFF000A, 32'h0,        32'h0000007F, 1'b0);
    vecs[21] = mkv(1'b1, 2'b01, 1'b0, 32'hFFFF000E, 32'h12348001, 32'h00000000, 1'b0);
    vecs[22] = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF000C, 32'h0,        32'h80010000, 1'b0);
    vecs[23] = mkv(1'b0, 2'b01, 1'b0, 32'hFFFF000E, 32'h0,        32'hFFFF8001, 1'b0);
    vecs[24] = mkv(1'b0, 2'b00, 1'b1, 32'hFFFF000C, 32'h0,        32'h00000000, 1'b0);
    vecs[25] = mkv(1'b1, 2'b10, 1'b0, 32'hFFFF003C, 32'h11223344, 32'h00000000, 1'b0);
    vecs[26] = mkv(1'b0, 2'b10, 1'b1, 32'hFFFF003C, 32'h0,        32'h11223344, 1'b0);
    vecs[27] = mkv(1'b0, 2'b11, 1'b0, 32'hFFFF0000, 32'h0,        32'h00000000, 1'b1);
    vecs[28] = mkv(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1);
    vecs[29] = mkv(1'b1, 2'b00, 1'b0, 32'hFFFF003D, 32'h000000A5, 32'h00000000, 1'b0);
    vecs[30] = mkv(1'b0, 2'b10, 1'b0, 32'hFFFF003C, 32'h0,        32'h1122A544, 1'b0);
    vecs[31] = mkv(1'b0, 2'b00, 1'b0, 32'hFFFF003D, 32'h0,        32'hFFFFFFA5, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(m1.busy), 32'd1);
    check("reset req_ready", 32'(m1.req_ready), 32'd0);
    check("reset rsp_valid", 32'(m1.rsp_valid), 32'd0);
    check("reset dut4 busy", 32'(m4.busy), 32'd1);
    rst1 = 1'b0;
    rst4 = 1'b0;
    wait_clear("dut1 clear cycles", 1);

    for (int i = 0; i < 32; i++) do_req(1, vecs[i]);

    // LAT=4: a normal load, then a store that a later reset must wipe out.
    do_req(4, mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0000, 32'h0, 32'h00000000, 1'b0));
    do_req(4, mkv(1'b1, 2'b10, 1'b0, 32'hFFFF0004, 32'h55AA55AA, 32'h00000000, 1'b0));
    do_req(4, mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0004, 32'h0, 32'h55AA55AA, 1'b0));

    // Accept a load, hold req_valid through WAIT, reset two cycles after acceptance.
    @(negedge clk);
    m4.req_we = 1'b0; m4.req_size = 2'b10; m4.req_unsigned = 1'b0;
    m4.req_addr = 32'hFFFF0004; m4.req_valid = 1'b1;
    n = 0;
    while (!m4.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut4 ready before held load", 32'(m4.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("dut4 ready in WAIT (1)", 32'(m4.req_ready), 32'd0);
    @(negedge clk);
    check("dut4 ready in WAIT (2)", 32'(m4.req_ready), 32'd0);
    rst4 = 1'b1;
    nrsp = 0;
    repeat (8) begin
      @(negedge clk);
      if (m4.rsp_valid) nrsp++;
    end
    check("dut4 dropped response count", 32'(nrsp), 32'd0);
    check("dut4 busy in reset", 32'(m4.busy), 32'd1);
    check("dut4 ready in reset", 32'(m4.req_ready), 32'd0);
    m4.req_valid = 1'b0;
    rst4 = 1'b0;
    wait_clear("dut4 clear cycles", 4);
    do_req(4, mkv(1'b0, 2'b10, 1'b0, 32'hFFFF0004, 32'h0, 32'h00000000, 1'b0));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_datos_bus.md
MEM_DATOS_BUS -- requirements
Module: mem_datos_bus

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'hFFFF0000, byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-003 The block SHALL have parameter LAT, default 1, request-to-response latency in cycles (1..4).
REQ-004 The block SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 The block SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port req_valid  input  1  request present.
REQ-007 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-008 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 The block SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 The block SHALL have port req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-011 The block SHALL have port req_addr  input  32  byte address.
REQ-012 The block SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 The block SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-014 The block SHALL have port rsp_rdata  output  32  load result, extended to 32 bits.
REQ-015 The block SHALL have port rsp_err  output  1  request rejected (misaligned, out of range, or illegal size).
REQ-016 The block SHALL have port busy  output  1  memory clear in progress.

Function
REQ-017 The block SHALL implement an FSM with states CLEAR, IDLE, WAIT and RESP.
REQ-018 CLEAR SHALL write 0 to one word per cycle, index 0 to DEPTH-1, then go to IDLE; busy=1 only in CLEAR.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid && req_ready, and all request fields SHALL be captured at acceptance.
REQ-020 On acceptance the FSM SHALL leave IDLE, and rsp_valid SHALL be 1 for exactly one cycle, LAT cycles after the acceptance edge; the FSM SHALL then return to IDLE.
REQ-021 req_valid outside IDLE SHALL be ignored; at most one request SHALL be outstanding.
REQ-022 Word index SHALL be (req_addr - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-023 A request SHALL be in range iff BASE_ADDR <= req_addr < BASE_ADDR + 4*DEPTH, without wrap-around past 32'hFFFFFFFF.
REQ-024 Misalignment SHALL be defined as: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-025 An out-of-range, misaligned or size-11 request SHALL give rsp_err=1 and rsp_rdata=0, and SHALL modify no memory.
REQ-026 Stores SHALL update only the addressed lanes: byte lane addr[1:0]; halfword lanes {addr[1],0} and {addr[1],1}; word all lanes. Other bytes of the word SHALL be preserved.
REQ-027 A store SHALL commit at the acceptance edge and respond with rsp_err=0, rsp_rdata=0.
REQ-028 Loads SHALL read the word at acceptance, select the lane(s), and extend per req_unsigned; word loads SHALL ignore req_unsigned.
REQ-029 Outside the response cycle, rsp_rdata and rsp_err SHALL be 0.
REQ-030 The memory array SHALL have a single write port; memory SHALL be read only at acceptance.

Reset
REQ-031 RST=1 at a clock edge in any state SHALL force state CLEAR, clear index 0, and set req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
REQ-032 A request pending at reset SHALL be dropped with no response; a store already committed SHALL not be undone but SHALL be cleared by CLEAR.
REQ-033 While RST is held, the FSM SHALL remain in CLEAR at index 0; clearing SHALL start on the first edge with RST=0 and finish DEPTH cycles later.

Verification
REQ-034 DEPTH=16, pulse RST -> busy=1 for 16 cycles after release, then req_ready=1; every word loads as 0.
REQ-035 LAT=1: store word 32'hDEADBEEF at 32'hFFFF0008, then load word -> rsp_rdata=32'hDEADBEEF exactly 1 cycle after acceptance, rsp_err=0.
REQ-036 After REQ-035, store byte 8'h7F at 32'hFFFF000A, then load signed byte at 32'hFFFF000B -> 32'hFFFFFFDE; load unsigned half at 32'hFFFF000A -> 32'h0000DE7F; load word -> 32'hDE7FBEEF.
REQ-037 Load word at 32'hFFFF0002, half at 32'hFFFF0001, any access at 32'hFFFEFFFC or BASE_ADDR+4*DEPTH, or size 11 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-038 LAT=4: accept a load, assert RST 2 cycles later -> no rsp_valid, busy=1; req_valid held during WAIT is not accepted.
